// File: rtl/mppc_gate_counter.sv
// Dark-count gate engine: a rising start level opens a fixed-length gate, rising edges of the
// asynchronous MPPC discriminator are counted inside it, and the result is offered via valid/ready.
module mppc_gate_counter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int GATE_WIDTH  = 27,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_uart,
    input  logic                   pulse_in,
    input  logic                   count_ready,
    output logic                   count_valid,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic                   overflow,
    output logic                   busy,
    output logic                   gate_probe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                 state_q, state_d;
    logic [3:0]             sync_q, sync_d;
    logic                   start_d_q, start_d_d;
    logic [GATE_WIDTH-1:0]  gate_q, gate_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d, acc_next;
    logic                   ovf_q, ovf_d, ovf_next;
    logic [COUNT_WIDTH-1:0] count_out_q, count_out_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;
    logic                   pulse_re, start_re;

    // sync_q[2:0] is the metastability chain; sync_q[3] is the previous q2 for edge detection
    assign pulse_re  = sync_q[2] & ~sync_q[3];
    assign start_re  = start_uart & ~start_d_q;
    assign sync_d    = {sync_q[2:0], pulse_in};
    assign start_d_d = start_uart;

    always_comb begin
        state_d     = state_q;
        gate_d      = gate_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        count_out_d = count_out_q;
        overflow_d  = overflow_q;
        valid_d     = valid_q;

        acc_next = acc_q;
        ovf_next = ovf_q;
        if (pulse_re) begin
            ovf_next = ovf_q | (&acc_q);
            acc_next = sat_inc(acc_q);
        end

        case (state_q)
            IDLE: begin
                if (start_re) begin
                    state_d = COUNT;
                    gate_d  = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            COUNT: begin
                gate_d = gate_q + 1'b1;
                acc_d  = acc_next;
                ovf_d  = ovf_next;
                // last gate cycle: latch including a strobe landing in this very cycle
                if (gate_q == GATE_LAST) begin
                    count_out_d = acc_next;
                    overflow_d  = ovf_next;
                    valid_d     = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (count_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            start_d_q   <= 1'b0;
            gate_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_out_q <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            start_d_q   <= start_d_d;
            gate_q      <= gate_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_out_q <= count_out_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
        end
    end

    assign count_valid = valid_q;
    assign count_out   = count_out_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != IDLE);
    assign gate_probe  = (state_q == COUNT);

endmodule

// File: doc/mppc_gate_counter.md
# mppc_gate_counter

Dark-count measurement engine for the MPPC dark counter design. It sits directly downstream of the UART RX start detector and consumes its `start_uart` level. On each rising edge of `start_uart` it opens a fixed counting gate and counts rising edges of the asynchronous MPPC discriminator output. At gate close it latches the count and offers it to the UART TX side through a valid/ready handshake.

## Interface

Parameters:
- `GATE_CYCLES`, 100000000: gate length in `clk` cycles (1 s at 100 MHz); must be ≥ 2.
- `GATE_WIDTH`, 27: width of the gate counter; must satisfy 2^GATE_WIDTH ≥ GATE_CYCLES.
- `COUNT_WIDTH`, 32: width of the pulse accumulator and of `count_out`.

Ports:
- `clk` in 1: on-board 100 MHz system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_uart` in 1: start level from the UART RX unit, already synchronous to `clk`.
- `pulse_in` in 1: MPPC discriminator output, asynchronous to `clk`.
- `count_ready` in 1: consumer accepts `count_out` when this is high together with `count_valid`.
- `count_valid` out 1: `count_out` holds a completed measurement.
- `count_out` out COUNT_WIDTH: latched pulse count of the last gate.
- `overflow` out 1: accumulator saturated during the last gate; latched with `count_out`.
- `busy` out 1: high in every state except IDLE.
- `gate_probe` out 1: high while the gate is open; oscilloscope debug output.

## Operation

- Every flop is reset asynchronously by `rst_n` low. On reset: state is IDLE, and all outputs are 0 (`count_out` is 0).
- `pulse_in` passes through a 3-flop synchronizer (q0..q2, each resets to 0). A fourth flop q3 holds the previous q2. The strobe `pulse_re = q2 & ~q3`.
- `start_uart` is registered into `start_d` (resets to 0). The strobe `start_re = start_uart & ~start_d`. Only a rising edge starts a measurement. Holding `start_uart` high starts exactly one measurement.
- State machine:
  - IDLE: on `start_re`, go to COUNT. At the same edge, clear the gate counter, the accumulator and the overflow bit.
  - COUNT: the gate counter increments every cycle. On each `pulse_re`, the accumulator increments by 1. The accumulator saturates at 2^COUNT_WIDTH−1. An increment attempted while it is saturated sets the internal overflow bit. In the cycle where the gate counter equals GATE_CYCLES−1, the edge latches the accumulator into `count_out`, including any `pulse_re` of that same cycle. The same edge latches the overflow bit into `overflow`, sets `count_valid` to 1, and moves to HOLD.
  - HOLD: `count_valid` stays high and `count_out`/`overflow` stay stable until a clock edge samples `count_ready` high. That edge clears `count_valid` and returns to IDLE.
- `start_re` is ignored in COUNT and HOLD. A start edge is never queued.
- `count_out` and `overflow` keep their last latched values through IDLE until the next gate closes.
- `busy` is high in COUNT and HOLD. `gate_probe` is high exactly in COUNT.
- A `pulse_in` pulse is counted reliably only if it is high for at least 1 `clk` period and low for at least 1 `clk` period. The maximum countable rate is 50 MHz.

## Timing

- Call E0 the clock edge at which `start_uart` is first sampled high while `start_d`=0 and the state is IDLE.
- The gate is open for exactly GATE_CYCLES cycles: COUNT holds from after E0 to after E0+GATE_CYCLES.
- `count_valid` rises after edge E0+GATE_CYCLES.
- `pulse_in` to `pulse_re` latency is 3 edges. A `pulse_in` rising edge is counted if its `pulse_re` cycle falls inside COUNT.
- Handshake: the transfer happens on an edge where `count_valid`=1 and `count_ready`=1. `count_valid` is low from the next cycle.
  - If `count_ready` is already high when `count_valid` rises, `count_valid` lasts exactly 1 cycle.
  - The earliest new start is accepted on the edge after the return to IDLE, given a fresh `start_re`.
- Reset mid-operation (any state) aborts the measurement immediately. Nothing is latched, all outputs go to 0, and the next start runs a full gate.

## Test plan

Use GATE_CYCLES=1000, GATE_WIDTH=10 unless noted.
- Reset: hold `rst_n` low, toggle all inputs -> all outputs 0 and `busy`=0. After release with no start, outputs stay 0.
- Basic count: assert `start_uart`, apply 10 pulses (5 cycles high, 5 low) inside the gate, keep `count_ready`=1 -> `count_valid` high for 1 cycle exactly 1000 edges after E0, `count_out`=10, `overflow`=0, `gate_probe` high for 1000 cycles.
- Empty gate and held start: `start_uart` held high for 3000 cycles, no pulses -> exactly one measurement, `count_out`=0, no second `count_valid`.
- Backpressure: `count_ready`=0 for 50 cycles after `count_valid` rises, with a new `start_uart` edge and pulses during HOLD -> `count_valid` and `count_out` stable, start ignored. Raise `count_ready` -> `count_valid` low next cycle, `busy`=0.
- Saturation: with COUNT_WIDTH=4, apply 20 pulses in the gate -> `count_out`=15, `overflow`=1. The next gate with 3 pulses gives `count_out`=3, `overflow`=0.
- Reset mid-gate and boundary pulses: pulse `rst_n` low at cycle 500 of a gate -> outputs 0, state IDLE. Restart and place one pulse whose `pulse_re` lands on gate cycle 999 and one on the cycle after the gate closes -> `count_out`=1.
